// File: rtl/axi4lite_reg_bank_if.sv
// AXI4-Lite register-bus bundle between the interconnect GP port and the register bank.
// The master modport drives addresses, data and response-ready; the slave modport returns readies and responses.
interface axi4lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_reg_bank.sv
// Purpose: AXI4-Lite slave register bank with RW control regs, RO status regs, byte strobes and SLVERR on decode miss.
// Latency: AW+W commit -> BVALID next cycle; AR handshake -> RVALID next cycle.
// Backpressure: BVALID/RVALID held until BREADY/RREADY; address/data readies low while a response is pending.
module axi4lite_reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    axi4lite_reg_bank_if.slave             s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] stat_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(NUM_BYTES);
    localparam int IDX_W     = ADDR_WIDTH - LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  bus_en;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_dat_q;
    logic [NUM_BYTES-1:0]  w_strb_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  aw_rdy, w_rdy, ar_rdy;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic [NUM_BYTES-1:0]  w_strb;
    logic [31:0]           w_idx, r_idx;
    logic                  w_hit, r_hit;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  bvalid, rvalid;

    // Readies stay low until the cycle after reset release so nothing is accepted during reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) bus_en <= 1'b0;
        else          bus_en <= 1'b1;
    end

    assign aw_rdy = bus_en && (w_state == W_IDLE) && !aw_held;
    assign w_rdy  = bus_en && (w_state == W_IDLE) && !w_held;
    assign ar_rdy = bus_en && (r_state == R_IDLE);

    assign aw_hs  = s_axi.awvalid && aw_rdy;
    assign w_hs   = s_axi.wvalid  && w_rdy;
    assign ar_hs  = s_axi.arvalid && ar_rdy;
    assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    // A same-cycle handshake bypasses the holding registers.
    assign w_addr = aw_held ? aw_addr_q : s_axi.awaddr;
    assign w_dat  = w_held  ? w_dat_q   : s_axi.wdata;
    assign w_strb = w_held  ? w_strb_q  : s_axi.wstrb;

    assign w_idx = 32'(w_addr[ADDR_WIDTH-1:LSB]);
    assign r_idx = 32'(s_axi.araddr[ADDR_WIDTH-1:LSB]);
    assign w_hit = w_idx < 32'(NUM_REGS);
    assign r_hit = r_idx < 32'(NUM_REGS);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == 32'(i)) begin
                if (RO_MASK[i]) rd_val = stat_in[i*DATA_WIDTH +: DATA_WIDTH];
                else            rd_val = regs[i];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: if (commit) w_state_nxt = W_RESP;
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        rvalid      = 1'b0;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                if (s_axi.rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_dat_q   <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi.awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_dat_q  <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
        end
    end

    // RO hits and misses commit nothing; only the response code distinguishes a miss.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            wr_pulse <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                bresp_q <= w_hit ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_idx == 32'(i) && !RO_MASK[i]) begin
                        wr_pulse[i] <= 1'b1;
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (w_strb[k]) regs[i][8*k +: 8] <= w_dat[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_val;
            rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    assign s_axi.awready = aw_rdy;
    assign s_axi.wready  = w_rdy;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = ar_rdy;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, w_addr[LSB-1:0], s_axi.araddr[LSB-1:0]};
endmodule

// File: tb/tb_axi4lite_reg_bank.sv
// Directed bench: two lock-stepped register banks (all-RW and reg1-RO) driven by one AXI master, outputs muxed by sel.
module tb_axi4lite_reg_bank;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam logic [DW-1:0] RV = 32'h1234_5678;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    axi4lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic sel = 1'b0;

    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;

    logic [NR*DW-1:0] ctrl_a, ctrl_b;
    logic [NR*DW-1:0] stat_a = {4{32'hEEEE_EEEE}};
    logic [NR*DW-1:0] stat_b = {32'h0, 32'h0, 32'hCAFE_0001, 32'h0};
    logic [NR-1:0]    pulse_a, pulse_b;

    assign bus_a.awaddr = awaddr;   assign bus_b.awaddr = awaddr;
    assign bus_a.awprot = 3'b000;   assign bus_b.awprot = 3'b000;
    assign bus_a.awvalid = awvalid; assign bus_b.awvalid = awvalid;
    assign bus_a.wdata = wdata;     assign bus_b.wdata = wdata;
    assign bus_a.wstrb = wstrb;     assign bus_b.wstrb = wstrb;
    assign bus_a.wvalid = wvalid;   assign bus_b.wvalid = wvalid;
    assign bus_a.bready = bready;   assign bus_b.bready = bready;
    assign bus_a.araddr = araddr;   assign bus_b.araddr = araddr;
    assign bus_a.arprot = 3'b000;   assign bus_b.arprot = 3'b000;
    assign bus_a.arvalid = arvalid; assign bus_b.arvalid = arvalid;
    assign bus_a.rready = rready;   assign bus_b.rready = rready;

    assign awready = sel ? bus_b.awready : bus_a.awready;
    assign wready  = sel ? bus_b.wready  : bus_a.wready;
    assign bvalid  = sel ? bus_b.bvalid  : bus_a.bvalid;
    assign bresp   = sel ? bus_b.bresp   : bus_a.bresp;
    assign arready = sel ? bus_b.arready : bus_a.arready;
    assign rvalid  = sel ? bus_b.rvalid  : bus_a.rvalid;
    assign rresp   = sel ? bus_b.rresp   : bus_a.rresp;
    assign rdata   = sel ? bus_b.rdata   : bus_a.rdata;

    axi4lite_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
                        .RO_MASK(4'b0000), .RESET_VAL(RV)) dut_a (
        .ACLK(aclk), .ARESETN(aresetn), .s_axi(bus_a),
        .ctrl_out(ctrl_a), .stat_in(stat_a), .wr_pulse(pulse_a));

    axi4lite_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
                        .RO_MASK(4'b0010), .RESET_VAL(RV)) dut_b (
        .ACLK(aclk), .ARESETN(aresetn), .s_axi(bus_b),
        .ctrl_out(ctrl_b), .stat_in(stat_b), .wr_pulse(pulse_b));

    int pc_a [NR];
    int pc_b [NR];
    initial for (int i = 0; i < NR; i++) begin pc_a[i] = 0; pc_b[i] = 0; end
    always @(negedge aclk) begin
        for (int i = 0; i < NR; i++) begin
            if (pulse_a[i]) pc_a[i]++;
            if (pulse_b[i]) pc_b[i]++;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at #1 after a posedge; AW/W raised after their delays, BREADY held off b_dly cycles of BVALID.
    task automatic axi_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp);
        bit aw_done, w_done, b_done, aw_fire, w_fire, b_seen, bad_rdy, b_drop;
        int cyc, b_wait;
        logic [1:0] resp;
        aw_done = 0; w_done = 0; b_done = 0; b_seen = 0; bad_rdy = 0; b_drop = 0;
        cyc = 0; b_wait = 0; resp = 2'b11;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!b_done && cyc < 60) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            bready  = b_wait >= b_dly;
            @(negedge aclk);
            if ((aw_done && awready) || (w_done && wready)) bad_rdy = 1;
            if (b_seen && !bvalid) b_drop = 1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            if (bvalid) begin
                b_seen = 1;
                if (bready) begin b_done = 1; resp = bresp; end
                else b_wait++;
            end
            @(posedge aclk); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0; bready = 0;
        check({tag, "_done"}, 128'(b_done), 128'(1));
        check({tag, "_bresp"}, 128'(resp), 128'(exp_resp));
        check({tag, "_rdy_stall"}, 128'(bad_rdy), 128'(0));
        check({tag, "_bvalid_hold"}, 128'(b_drop), 128'(0));
    endtask

    task automatic axi_read(input string tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
        bit ar_fire, r_done;
        int cyc;
        logic [DW-1:0] data;
        logic [1:0] resp;
        r_done = 0; cyc = 0; data = '1; resp = 2'b11;
        araddr = addr; arvalid = 1; rready = 1;
        while (!r_done && cyc < 40) begin
            @(negedge aclk);
            ar_fire = arvalid && arready;
            if (rvalid) begin r_done = 1; data = rdata; resp = rresp; end
            @(posedge aclk); #1;
            if (ar_fire) arvalid = 0;
            cyc++;
        end
        arvalid = 0; rready = 0;
        check({tag, "_done"}, 128'(r_done), 128'(1));
        check({tag, "_rdata"}, 128'(data), 128'(exp_data));
        check({tag, "_rresp"}, 128'(resp), 128'(exp_resp));
    endtask

    initial begin
        int p0, p_other, sum0, sum1, cyc;
        logic [NR*DW-1:0] snap;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", 128'(awready), 128'(0));
        check("rst_wready", 128'(wready), 128'(0));
        check("rst_arready", 128'(arready), 128'(0));
        check("rst_bvalid", 128'(bvalid), 128'(0));
        check("rst_rvalid", 128'(rvalid), 128'(0));
        check("rst_bresp_rresp", 128'({bresp, rresp}), 128'(0));
        check("rst_rdata", 128'(rdata), 128'(0));
        check("rst_pulse", 128'({pulse_a, pulse_b}), 128'(0));
        check("rst_ctrl", 128'(ctrl_a), {4{RV}});
        @(posedge aclk); #1;
        aresetn = 1;
        @(posedge aclk); #1;

        // T1: plain writes then readback
        axi_write("t1_w0", 6'h00, 32'd1, 4'hF, 0, 0, 0, 2'b00);
        axi_write("t1_w1", 6'h04, 32'd2, 4'hF, 0, 0, 0, 2'b00);
        axi_write("t1_w2", 6'h08, 32'd3, 4'hF, 0, 0, 0, 2'b00);
        axi_write("t1_w3", 6'h0C, 32'd4, 4'hF, 0, 0, 0, 2'b00);
        check("t1_ctrl", 128'(ctrl_a), {32'd4, 32'd3, 32'd2, 32'd1});
        axi_read("t1_r0", 6'h00, 32'd1, 2'b00);
        axi_read("t1_r1", 6'h04, 32'd2, 2'b00);
        axi_read("t1_r2", 6'h08, 32'd3, 2'b00);
        axi_read("t1_r3", 6'h0C, 32'd4, 2'b00);

        // T2: byte strobes and per-write pulses
        p0 = pc_a[0]; p_other = pc_a[1] + pc_a[2] + pc_a[3];
        axi_write("t2_full", 6'h00, 32'hAABB_CCDD, 4'hF, 0, 0, 0, 2'b00);
        check("t2_pulse_1", 128'(pc_a[0] - p0), 128'(1));
        axi_write("t2_strb", 6'h01, 32'h1122_3344, 4'b0101, 0, 0, 0, 2'b00);
        check("t2_pulse_2", 128'(pc_a[0] - p0), 128'(2));
        check("t2_pulse_other", 128'(pc_a[1] + pc_a[2] + pc_a[3] - p_other), 128'(0));
        axi_read("t2_r0", 6'h00, 32'hAA22_CC44, 2'b00);

        // T3: W ahead of AW, then AW ahead of W, BREADY stalled 5 cycles
        sum0 = pc_a[2]; sum1 = pc_a[3];
        axi_write("t3_w_first", 6'h08, 32'h0000_00A5, 4'hF, 3, 0, 5, 2'b00);
        axi_write("t3_aw_first", 6'h0C, 32'h0000_005A, 4'hF, 0, 3, 5, 2'b00);
        check("t3_commits_r2", 128'(pc_a[2] - sum0), 128'(1));
        check("t3_commits_r3", 128'(pc_a[3] - sum1), 128'(1));
        axi_read("t3_r2", 6'h08, 32'h0000_00A5, 2'b00);
        axi_read("t3_r3", 6'h0C, 32'h0000_005A, 2'b00);

        // T4: read-only register on the second bank
        sel = 1;
        p0 = pc_b[1];
        axi_write("t4_ro_w", 6'h04, 32'h5, 4'hF, 0, 0, 0, 2'b00);
        check("t4_no_pulse", 128'(pc_b[1] - p0), 128'(0));
        check("t4_ctrl_r1", 128'(ctrl_b[DW +: DW]), 128'(RV));
        axi_read("t4_ro_r", 6'h04, 32'hCAFE_0001, 2'b00);
        axi_read("t4_rw_r3", 6'h0C, 32'h0000_005A, 2'b00);
        sel = 0;

        // T5: decode misses
        snap = ctrl_a;
        sum0 = pc_a[0] + pc_a[1] + pc_a[2] + pc_a[3];
        axi_write("t5_miss_w", 6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10);
        check("t5_ctrl_same", 128'(ctrl_a), 128'(snap));
        check("t5_no_pulse", 128'(pc_a[0] + pc_a[1] + pc_a[2] + pc_a[3] - sum0), 128'(0));
        axi_read("t5_miss_r", 6'h10, 32'h0, 2'b10);
        axi_read("t5_miss_top", 6'h3C, 32'h0, 2'b10);
        axi_read("t5_hit_after", 6'h00, 32'hAA22_CC44, 2'b00);

        // T6: reset while a write response is pending
        awaddr = 6'h00; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            @(posedge aclk); #1;
            if (!bvalid) begin awvalid = !awready && awvalid; end
            cyc++;
        end
        check("t6_bvalid_seen", 128'(bvalid), 128'(1));
        awvalid = 0; wvalid = 0;
        aresetn = 0;
        @(negedge aclk);
        check("t6_bvalid_rst", 128'(bvalid), 128'(0));
        check("t6_ctrl_rst", 128'(ctrl_a), {4{RV}});
        @(posedge aclk); #1;
        aresetn = 1;
        @(posedge aclk); #1;
        axi_write("t6_after", 6'h00, 32'h0000_0077, 4'hF, 0, 0, 0, 2'b00);
        axi_read("t6_r0", 6'h00, 32'h0000_0077, 2'b00);
        axi_read("t6_r1", 6'h04, RV, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
